// File: rtl/divisor_secuencial_if.sv
// Request/result and shared-subtractor bus for the sequential restoring divider.
// Latency: none, wires only.
// Backpressure: the requester watches ready; start is only honoured while ready=1.
interface divisor_secuencial_if #(
    parameter int M = 4
);
    // Request side (ALU-op decoder)
    logic         start;
    logic [M-1:0] dividend;
    logic [M-1:0] divisor;
    // Status and results (towards result/flag registers)
    logic         ready;
    logic         busy;
    logic         done;
    logic         div_zero;
    logic [M-1:0] quotient;
    logic [M-1:0] remainder;
    // Shared subtractor
    logic [M-1:0] sub_a;
    logic [M-1:0] sub_b;
    logic [M-1:0] sub_r;
    logic         sub_c;
    logic         sub_n;
    logic         sub_v;
    logic         sub_z;

    // Surrounding system: issues requests, owns the subtractor, consumes results
    modport master (
        output start, dividend, divisor,
        output sub_r, sub_c, sub_n, sub_v, sub_z,
        input  ready, busy, done, div_zero, quotient, remainder,
        input  sub_a, sub_b
    );

    // Divider sequencer
    modport slave (
        input  start, dividend, divisor,
        input  sub_r, sub_c, sub_n, sub_v, sub_z,
        output ready, busy, done, div_zero, quotient, remainder,
        output sub_a, sub_b
    );
endinterface

// File: rtl/divisor_secuencial.sv
// Unsigned restoring divider that drives an external M-bit subtractor, one step per clock.
// Latency: M ITER cycles then a one-cycle DONE (M+1 per op); divide-by-zero reports in the first cycle.
// Backpressure: ready=0 while iterating; start during ITER is ignored and operands are not re-sampled.
module divisor_secuencial #(
    parameter int M = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    divisor_secuencial_if.slave   bus
);
    localparam int CW = $clog2(M);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [M-1:0]   p_q;        // partial remainder
    logic [M-1:0]   q_q;        // dividend shifting out / quotient shifting in
    logic [M-1:0]   d_q;        // latched divisor
    logic [CW-1:0]  cnt_q;
    logic [M-1:0]   quot_q;
    logic [M-1:0]   rem_q;
    logic           dz_q;

    logic [M-1:0]   p_shift;
    logic [M-1:0]   p_d;
    logic [M-1:0]   q_d;
    logic           last_iter;

    // Flags the subtractor produces that this sequencer has no use for.
    logic           unused_flags;
    assign unused_flags = ^{bus.sub_n, bus.sub_v, bus.sub_z};

    // P < D is invariant, so shifting in the next dividend bit cannot overflow M bits.
    assign p_shift   = {p_q[M-2:0], q_q[M-1]};
    // Restore (keep the shifted value) when the subtraction would have borrowed.
    assign p_d       = bus.sub_c ? bus.sub_r : p_shift;
    assign q_d       = {q_q[M-2:0], bus.sub_c};
    assign last_iter = (cnt_q == CW'(M - 1));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: IDLE and DONE both accept a new operation, so DONE lasts one cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    state_d = (bus.divisor == '0) ? S_DONE : S_ITER;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ITER: begin
                if (last_iter) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs: status from state, subtractor operands only while iterating
    always_comb begin
        bus.ready = 1'b1;
        bus.busy  = 1'b0;
        bus.done  = 1'b0;
        bus.sub_a = '0;
        bus.sub_b = '0;
        case (state_q)
            S_ITER: begin
                bus.ready = 1'b0;
                bus.busy  = 1'b1;
                bus.sub_a = p_shift;
                bus.sub_b = d_q;
            end
            S_DONE: begin
                bus.done  = 1'b1;
            end
            default: begin
                bus.ready = 1'b1;
            end
        endcase
    end

    // Datapath: latch operands on accept, step the division, publish results entering DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_q    <= '0;
            q_q    <= '0;
            d_q    <= '0;
            cnt_q  <= '0;
            quot_q <= '0;
            rem_q  <= '0;
            dz_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        if (bus.divisor != '0) begin
                            d_q   <= bus.divisor;
                            q_q   <= bus.dividend;
                            p_q   <= '0;
                            cnt_q <= '0;
                        end else begin
                            quot_q <= '1;
                            rem_q  <= bus.dividend;
                            dz_q   <= 1'b1;
                        end
                    end
                end
                S_ITER: begin
                    p_q   <= p_d;
                    q_q   <= q_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (last_iter) begin
                        quot_q <= q_d;
                        rem_q  <= p_d;
                        dz_q   <= 1'b0;
                    end
                end
                default: begin
                    cnt_q <= '0;
                end
            endcase
        end
    end

    assign bus.quotient  = quot_q;
    assign bus.remainder = rem_q;
    assign bus.div_zero  = dz_q;

endmodule

// File: tb/tb_divisor_secuencial.sv
module tb_divisor_secuencial;
    logic clk;
    logic rst_n;

    divisor_secuencial_if #(.M(4)) bus4 ();
    divisor_secuencial_if #(.M(8)) bus8 ();

    divisor_secuencial #(.M(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4.slave));
    divisor_secuencial #(.M(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8.slave));

    // Behavioural subtractors shared with the dividers
    assign bus4.sub_r = bus4.sub_a - bus4.sub_b;
    assign bus4.sub_c = (bus4.sub_a >= bus4.sub_b);
    assign bus4.sub_n = bus4.sub_r[3];
    assign bus4.sub_z = (bus4.sub_r == 4'd0);
    assign bus4.sub_v = (bus4.sub_a[3] != bus4.sub_b[3]) && (bus4.sub_r[3] != bus4.sub_a[3]);
    assign bus8.sub_r = bus8.sub_a - bus8.sub_b;
    assign bus8.sub_c = (bus8.sub_a >= bus8.sub_b);
    assign bus8.sub_n = bus8.sub_r[7];
    assign bus8.sub_z = (bus8.sub_r == 8'd0);
    assign bus8.sub_v = (bus8.sub_a[7] != bus8.sub_b[7]) && (bus8.sub_r[7] != bus8.sub_a[7]);

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Operation-level model of the M=4 divider: which cycle each result appears in and its value
    int       cyc      = 0;
    int       done_cyc = 0;
    bit       pend     = 1'b0;
    int       pq = 0, pr = 0, pb = 0;
    bit       pdz = 1'b0;
    int       hq = 0, hr = 0;
    bit       hdz = 1'b0;
    bit       m_ready;
    bit       eb, ed;

    always @(posedge clk) begin
        if (!rst_n) begin
            pend = 1'b0;
            hq   = 0;
            hr   = 0;
            hdz  = 1'b0;
        end else begin
            m_ready = !pend || (cyc >= done_cyc);
            if (pend && cyc >= done_cyc) pend = 1'b0;
            if (m_ready && bus4.start) begin
                pend = 1'b1;
                pb   = int'(bus4.divisor);
                if (bus4.divisor == 4'd0) begin
                    done_cyc = cyc + 1;
                    pq  = 15;
                    pr  = int'(bus4.dividend);
                    pdz = 1'b1;
                end else begin
                    done_cyc = cyc + 1 + 4;
                    pq  = int'(bus4.dividend) / int'(bus4.divisor);
                    pr  = int'(bus4.dividend) % int'(bus4.divisor);
                    pdz = 1'b0;
                end
            end
        end
        cyc = cyc + 1;
        if (pend && cyc == done_cyc) begin
            hq  = pq;
            hr  = pr;
            hdz = pdz;
        end
    end

    // Per-cycle comparison of the M=4 divider against the model
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_ready", int'(bus4.ready), 1);
            chk("rst_busy", int'(bus4.busy), 0);
            chk("rst_done", int'(bus4.done), 0);
            chk("rst_div_zero", int'(bus4.div_zero), 0);
            chk("rst_quotient", int'(bus4.quotient), 0);
            chk("rst_remainder", int'(bus4.remainder), 0);
            chk("rst_sub_a", int'(bus4.sub_a), 0);
            chk("rst_sub_b", int'(bus4.sub_b), 0);
        end else begin
            eb = pend && (cyc < done_cyc);
            ed = pend && (cyc == done_cyc);
            chk("ready", int'(bus4.ready), int'(!eb));
            chk("busy", int'(bus4.busy), int'(eb));
            chk("done", int'(bus4.done), int'(ed));
            chk("div_zero", int'(bus4.div_zero), int'(hdz));
            chk("quotient", int'(bus4.quotient), hq);
            chk("remainder", int'(bus4.remainder), hr);
            if (!eb) chk("sub_a_idle", int'(bus4.sub_a), 0);
            chk("sub_b", int'(bus4.sub_b), eb ? pb : 0);
        end
    end

    // Issue one M=4 op from a falling edge and check hand-computed results and latency
    task automatic run_op4(input int a, input int b, input int eq, input int er,
                           input int edz, input int elat, input string nm);
        int lat;
        bus4.start    = 1'b1;
        bus4.dividend = 4'(a);
        bus4.divisor  = 4'(b);
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        bus4.start = 1'b0;
        while (!bus4.done && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        chk({nm, "_latency"}, lat, elat);
        chk({nm, "_quotient"}, int'(bus4.quotient), eq);
        chk({nm, "_remainder"}, int'(bus4.remainder), er);
        chk({nm, "_div_zero"}, int'(bus4.div_zero), edz);
    endtask

    // Issue one M=8 op; expectations from plain integer division
    task automatic run_op8(input int a, input int b);
        int lat, eq, er, elat;
        eq   = (b == 0) ? 255 : a / b;
        er   = (b == 0) ? a : a % b;
        elat = (b == 0) ? 1 : 9;
        bus8.start    = 1'b1;
        bus8.dividend = 8'(a);
        bus8.divisor  = 8'(b);
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        bus8.start = 1'b0;
        while (!bus8.done && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        chk("m8_latency", lat, elat);
        chk("m8_quotient", int'(bus8.quotient), eq);
        chk("m8_remainder", int'(bus8.remainder), er);
        chk("m8_div_zero", int'(bus8.div_zero), int'(b == 0));
    endtask

    initial begin
        int lat;
        rst_n         = 1'b0;
        bus4.start    = 1'b0;
        bus4.dividend = '0;
        bus4.divisor  = '0;
        bus8.start    = 1'b0;
        bus8.dividend = '0;
        bus8.divisor  = '0;
        repeat (2) @(negedge clk);
        chk("reset_ready_lit", int'(bus4.ready), 1);
        chk("reset_quotient_lit", int'(bus4.quotient), 0);
        #2 rst_n = 1'b1;
        @(negedge clk);

        // Basic operations
        run_op4(13, 3, 4, 1, 0, 5, "d13_3");
        run_op4(15, 1, 15, 0, 0, 5, "d15_1");
        run_op4(5, 7, 0, 5, 0, 5, "d5_7");
        run_op4(15, 15, 1, 0, 0, 5, "d15_15");
        run_op4(9, 0, 15, 9, 1, 1, "d9_0");
        run_op4(0, 4, 0, 0, 0, 5, "d0_4");
        repeat (2) @(negedge clk);

        // Back-to-back: second start lands in the DONE cycle of the first
        run_op4(13, 3, 4, 1, 0, 5, "b2b_first");
        run_op4(6, 2, 3, 0, 0, 5, "b2b_second");
        run_op4(9, 0, 15, 9, 1, 1, "b2b_div0");
        run_op4(14, 4, 3, 2, 0, 5, "b2b_after_div0");
        @(negedge clk);

        // Start pulses while busy must be ignored
        bus4.start    = 1'b1;
        bus4.dividend = 4'd13;
        bus4.divisor  = 4'd3;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        bus4.dividend = 4'd2;
        bus4.divisor  = 4'd1;
        repeat (2) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        bus4.start = 1'b0;
        while (!bus4.done && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        chk("ignore_latency", lat, 5);
        chk("ignore_quotient", int'(bus4.quotient), 4);
        chk("ignore_remainder", int'(bus4.remainder), 1);
        @(negedge clk);

        // Reset in the middle of an operation aborts it
        bus4.start    = 1'b1;
        bus4.dividend = 4'd15;
        bus4.divisor  = 4'd2;
        @(posedge clk);
        @(negedge clk);
        bus4.start = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", int'(bus4.busy), 0);
        chk("abort_ready", int'(bus4.ready), 1);
        chk("abort_quotient", int'(bus4.quotient), 0);
        chk("abort_remainder", int'(bus4.remainder), 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (6) @(negedge clk);
        run_op4(8, 3, 2, 2, 0, 5, "after_abort");

        // M=8 corners plus a random sweep
        run_op8(255, 1);
        run_op8(0, 5);
        run_op8(255, 255);
        run_op8(1, 255);
        run_op8(200, 0);
        run_op8(128, 7);
        for (int i = 0; i < 300; i++) begin
            int a, b;
            a = int'($urandom_range(0, 255));
            if (i % 16 == 0)     b = 0;
            else if (i % 3 == 0) b = int'($urandom_range(1, 15));
            else                 b = int'($urandom_range(1, 255));
            run_op8(a, b);
        end

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
